cpri_tx_pack: RTL

- Packer directly upstream of the CPRI TX loop buffer writer.
- Takes a stream of 64-bit compressed IQ payload words per symbol/antenna packet.
- Writes payload words to buffer addresses 3..98 as they arrive, then writes a 3-word header to addresses 0..2.
- Asserts the commit strobe (wlast) on the final header write, so each slot in the loop buffer is complete before it is released.

---
 rtl/cpri_tx_pack.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/cpri_tx_pack.sv
// cpri_tx_pack: packs 64-bit IQ payload words into a loop buffer slot,
// payload first at HDR_WORDS.., then the 3-word header with commit strobe.
module cpri_tx_pack #(
  parameter int          PAY_WORDS  = 96,
  parameter int          HDR_WORDS  = 3,
  parameter logic [15:0] MAGIC      = 16'hCB01,
  parameter int          ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_iq_vld,
  input  logic                  i_iq_sop,
  input  logic                  i_iq_eop,
  input  logic [63:0]           i_iq_data,
  input  logic [7:0]            i_slot_idx,
  input  logic [3:0]            i_sym_idx,
  input  logic [7:0]            i_ant_idx,
  input  logic [63:0]           i_hdr_info,
  output logic                  o_iq_rdy,
  output logic                  o_cpri_wen,
  output logic [ADDR_WIDTH-1:0] o_cpri_waddr,
  output logic [63:0]           o_cpri_wdata,
  output logic                  o_cpri_wlast,
  output logic [7:0]            o_pkt_seq,
  output logic                  o_err,
  output logic [7:0]            o_err_cnt
);

  localparam int IW = $clog2(PAY_WORDS + 1);
  localparam logic [IW-1:0] LAST = IW'(PAY_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(HDR_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_PAY, S_PAD, S_HDR0, S_HDR1, S_HDR2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_idx, w_idx_nxt;
  logic [63:0]     r_acc, w_acc_nxt;
  logic [7:0]      r_seq;
  logic [7:0]      r_slot, r_ant;
  logic [3:0]      r_sym;
  logic [63:0]     r_info;
  logic            r_wen, r_wlast, r_err;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [63:0]     r_wdata;
  logic [7:0]      r_pkt_seq, r_err_cnt;

  logic            w_take, w_latch, w_err, w_commit;
  logic            w_wen, w_wlast;
  logic [ADDR_WIDTH-1:0] w_waddr, w_pay_addr;
  logic [63:0]     w_wdata;

  assign o_iq_rdy   = (r_state == S_IDLE) || (r_state == S_PAY);
  assign w_take     = i_iq_vld && o_iq_rdy;
  assign w_pay_addr = BASE + ADDR_WIDTH'(r_idx);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_acc_nxt   = r_acc;
    w_latch     = 1'b0;
    w_err       = 1'b0;
    w_commit    = 1'b0;
    w_wen       = 1'b0;
    w_waddr     = '0;
    w_wdata     = '0;
    w_wlast     = 1'b0;
    unique case (r_state)
      S_IDLE, S_PAY: begin
        if (w_take && i_iq_sop) begin
          // a sop always (re)starts the slot, aborting any open packet
          w_latch     = 1'b1;
          w_wen       = 1'b1;
          w_waddr     = BASE;
          w_wdata     = i_iq_data;
          w_acc_nxt   = i_iq_data;
          w_idx_nxt   = IW'(1);
          w_err       = (r_state == S_PAY) || i_iq_eop;
          w_state_nxt = i_iq_eop ? S_PAD : S_PAY;
        end else if (w_take && r_state == S_IDLE) begin
          w_err = 1'b1;
        end else if (w_take) begin
          w_wen     = 1'b1;
          w_waddr   = w_pay_addr;
          w_wdata   = i_iq_data;
          w_acc_nxt = r_acc ^ i_iq_data;
          w_idx_nxt = r_idx + IW'(1);
          if (r_idx == LAST) begin
            w_err       = !i_iq_eop;
            w_state_nxt = S_HDR0;
          end else if (i_iq_eop) begin
            w_err       = 1'b1;
            w_state_nxt = S_PAD;
          end
        end
      end
      S_PAD: begin
        w_wen     = 1'b1;
        w_waddr   = w_pay_addr;
        w_idx_nxt = r_idx + IW'(1);
        if (r_idx == LAST) w_state_nxt = S_HDR0;
      end
      S_HDR0: begin
        w_wen       = 1'b1;
        w_waddr     = ADDR_WIDTH'(0);
        w_wdata     = {MAGIC, r_seq, r_slot, r_sym, 4'h0,
                       r_ant, 16'(PAY_WORDS)};
        w_state_nxt = S_HDR1;
      end
      S_HDR1: begin
        w_wen       = 1'b1;
        w_waddr     = ADDR_WIDTH'(1);
        w_wdata     = r_acc;
        w_state_nxt = S_HDR2;
      end
      S_HDR2: begin
        w_wen       = 1'b1;
        w_waddr     = ADDR_WIDTH'(2);
        w_wdata     = r_info;
        w_wlast     = 1'b1;
        w_commit    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_acc     <= '0;
      r_seq     <= '0;
      r_slot    <= '0;
      r_sym     <= '0;
      r_ant     <= '0;
      r_info    <= '0;
      r_wen     <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_wlast   <= 1'b0;
      r_pkt_seq <= '0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_acc   <= w_acc_nxt;
      r_wen   <= w_wen;
      r_waddr <= w_waddr;
      r_wdata <= w_wdata;
      r_wlast <= w_wlast;
      if (w_latch) begin
        r_slot <= i_slot_idx;
        r_sym  <= i_sym_idx;
        r_ant  <= i_ant_idx;
        r_info <= i_hdr_info;
      end
      if (w_commit) begin
        r_pkt_seq <= r_seq;
        r_seq     <= r_seq + 8'd1;
      end
      if (w_err) begin
        r_err <= 1'b1;
        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign o_cpri_wen   = r_wen;
  assign o_cpri_waddr = r_waddr;
  assign o_cpri_wdata = r_wdata;
  assign o_cpri_wlast = r_wlast;
  assign o_pkt_seq    = r_pkt_seq;
  assign o_err        = r_err;
  assign o_err_cnt    = r_err_cnt;

endmodule
